// File: rtl/stream_join_fork_buff.sv
// stream_join_fork_buff: NIN-way join into a DEPTH-entry elastic buffer, forked to NOUT independently tracked consumers
module stream_join_fork_buff #(
  parameter int DATAW = 34,
  parameter int NIN = 2,
  parameter int NOUT = 2,
  parameter int DEPTH = 16,
  parameter int AFULL_TH = 14,
  localparam int CNTW = $clog2(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NIN-1:0]        i_ivalid,
  input  logic [NIN*DATAW-1:0]  i_in_data,
  output logic                  o_iready,
  output logic [NIN*DATAW-1:0]  o_out_data,
  output logic [NOUT-1:0]       o_ovalid,
  input  logic [NOUT-1:0]       i_oready,
  output logic [CNTW-1:0]       o_count,
  output logic                  o_afull
);
  localparam int PW = $clog2(DEPTH);
  logic [NIN*DATAW-1:0] r_mem [DEPTH];
  logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CNTW-1:0]      r_count;
  logic [NOUT-1:0]      r_done;
  logic                 w_nempty, w_pop;
  assign w_nempty   = r_count != '0;
  // registered count only: a same-cycle pop never frees room for a push
  assign o_iready   = i_rst_n & (r_count != CNTW'(DEPTH)) & (&i_ivalid);
  assign o_ovalid   = {NOUT{w_nempty}} & ~r_done;
  assign w_pop      = w_nempty & (&(r_done | i_oready));
  assign o_out_data = w_nempty ? r_mem[r_rd_ptr] : '0;
  assign o_count    = r_count;
  assign o_afull    = r_count >= CNTW'(AFULL_TH);
  always_ff @(posedge i_clk)
    if (o_iready) r_mem[r_wr_ptr] <= i_in_data;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_done   <= '0;
    end else begin
      if (o_iready) r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
      if (w_pop) r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
      r_done  <= w_pop ? '0 : r_done | (o_ovalid & i_oready);
      r_count <= r_count + CNTW'(o_iready) - CNTW'(w_pop);
    end
endmodule

// File: tb/tb_stream_join_fork_buff.sv
// tb_stream_join_fork_buff: directed join/fork scenarios plus per-consumer scoreboard on a DEPTH=16 and a DEPTH=5 instance
module tb_stream_join_fork_buff;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] iv_a, or_a, ov_a, iv_b, or_b, ov_b;
  logic [67:0] id_a, od_a, id_b, od_b;
  logic ir_a, ir_b, af_a, af_b;
  logic [4:0] cnt_a;
  logic [2:0] cnt_b;
  int n_tests = 0, n_fail = 0;
  logic [67:0] sb[2][2][$];
  always #5 clk = ~clk;
  stream_join_fork_buff dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_ivalid(iv_a), .i_in_data(id_a), .o_iready(ir_a),
    .o_out_data(od_a), .o_ovalid(ov_a), .i_oready(or_a), .o_count(cnt_a), .o_afull(af_a));
  stream_join_fork_buff #(.DEPTH(5), .AFULL_TH(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_ivalid(iv_b), .i_in_data(id_b), .o_iready(ir_b),
    .o_out_data(od_b), .o_ovalid(ov_b), .i_oready(or_b), .o_count(cnt_b), .o_afull(af_b));
  task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // each consumer owns a queue of entries it has yet to take; occupancy is the longer queue
  task automatic mon(input int d, input logic rn, input logic [1:0] iv, input logic [67:0] id,
                     input logic ir, input logic [1:0] ov, input logic [1:0] ordy, input logic [67:0] od,
                     input logic [4:0] c, input logic af, input int depth, input int th);
    int cnt;
    logic er;
    logic [1:0] ev;
    logic [67:0] head;
    if (!rn) begin
      check($sformatf("d%0d_rst_ovalid", d), {66'b0, ov}, 68'd0);
      check($sformatf("d%0d_rst_count", d), {63'b0, c}, 68'd0);
      sb[d][0].delete();
      sb[d][1].delete();
      return;
    end
    cnt = (sb[d][0].size() > sb[d][1].size()) ? sb[d][0].size() : sb[d][1].size();
    er = (cnt != depth) && (&iv);
    check($sformatf("d%0d_count", d), {63'b0, c}, 68'(cnt));
    check($sformatf("d%0d_afull", d), {67'b0, af}, {67'b0, cnt >= th});
    check($sformatf("d%0d_iready", d), {67'b0, ir}, {67'b0, er});
    for (int k = 0; k < 2; k++) ev[k] = (cnt != 0) && (sb[d][k].size() == cnt);
    check($sformatf("d%0d_ovalid", d), {66'b0, ov}, {66'b0, ev});
    head = (cnt == 0) ? 68'd0 : (sb[d][0].size() == cnt) ? sb[d][0][0] : sb[d][1][0];
    check($sformatf("d%0d_head", d), od, head);
    for (int k = 0; k < 2; k++) if (ev[k] && ordy[k]) void'(sb[d][k].pop_front());
    if (er) begin
      sb[d][0].push_back(id);
      sb[d][1].push_back(id);
    end
  endtask
  always @(negedge clk) begin
    mon(0, rst_n, iv_a, id_a, ir_a, ov_a, or_a, od_a, cnt_a, af_a, 16, 14);
    mon(1, rst_n, iv_b, id_b, ir_b, ov_b, or_b, od_b, {2'b0, cnt_b}, af_b, 5, 4);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [67:0] lanes(input int hi, input int lo);
    return {34'(hi), 34'(lo)};
  endfunction
  initial begin
    int n, cyc;
    rst_n = 0; iv_a = 2'b11; id_a = '0; or_a = 2'b11; iv_b = 0; id_b = '0; or_b = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_iready", {67'b0, ir_a}, 68'd0);
    check("rst_ovalid", {66'b0, ov_a}, 68'd0);
    check("rst_count", {63'b0, cnt_a}, 68'd0);
    check("rst_odata", od_a, 68'd0);
    check("rst_afull", {67'b0, af_a}, 68'd0);
    step(); rst_n = 1; id_a = lanes(7, 6);
    @(negedge clk); check("rel_iready", {67'b0, ir_a}, 68'd1);
    step(); iv_a = 0;
    @(negedge clk);
    check("rel_ovalid", {66'b0, ov_a}, 68'd3);
    check("rel_odata", od_a, lanes(7, 6));
    step(); or_a = 0; iv_a = 2'b01; id_a = lanes(0, 1);
    @(negedge clk); check("pj_iready", {67'b0, ir_a}, 68'd0);
    step();
    @(negedge clk); check("pj_count", {63'b0, cnt_a}, 68'd0);
    step(); iv_a = 2'b11; id_a = lanes(2, 1);
    @(negedge clk); check("pj_iready_all", {67'b0, ir_a}, 68'd1);
    step(); iv_a = 0;
    @(negedge clk);
    check("pj_ovalid", {66'b0, ov_a}, 68'd3);
    check("pj_odata", od_a, lanes(2, 1));
    step(); or_a = 2'b11;
    step(); or_a = 0;
    for (int i = 0; i < 16; i++) begin
      iv_a = 2'b11; id_a = lanes(i, i);
      step();
    end
    id_a = lanes(16, 16);
    @(negedge clk);
    check("full_count", {63'b0, cnt_a}, 68'd16);
    check("full_afull", {67'b0, af_a}, 68'd1);
    check("full_iready", {67'b0, ir_a}, 68'd0);
    step(); or_a = 2'b11;
    @(negedge clk); check("full_pop_iready", {67'b0, ir_a}, 68'd0);
    step();
    @(negedge clk);
    check("after_pop_count", {63'b0, cnt_a}, 68'd15);
    check("after_pop_iready", {67'b0, ir_a}, 68'd1);
    step(); iv_a = 0;
    repeat (20) step();
    or_a = 0; iv_a = 2'b11; id_a = lanes('hA5, 'hA5);
    step(); iv_a = 0; or_a = 2'b01;
    step();
    @(negedge clk);
    check("skew_ovalid", {66'b0, ov_a}, 68'd2);
    check("skew_count", {63'b0, cnt_a}, 68'd1);
    step(); step(); or_a = 2'b10;
    @(negedge clk);
    check("skew_hold_count", {63'b0, cnt_a}, 68'd1);
    check("skew_hold_ovalid", {66'b0, ov_a}, 68'd2);
    step();
    @(negedge clk);
    check("skew_pop_count", {63'b0, cnt_a}, 68'd0);
    check("skew_pop_ovalid", {66'b0, ov_a}, 68'd0);
    step(); or_a = 0; iv_a = 2'b11;
    for (int i = 0; i < 7; i++) begin
      id_a = lanes(100 + i, i);
      step();
    end
    iv_a = 0;
    @(negedge clk); check("mid_count", {63'b0, cnt_a}, 68'd7);
    #2 rst_n = 0;
    #1;
    check("mid_rst_ovalid", {66'b0, ov_a}, 68'd0);
    check("mid_rst_count", {63'b0, cnt_a}, 68'd0);
    check("mid_rst_odata", od_a, 68'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1; or_a = 2'b11;
    @(negedge clk); check("mid_rel_count", {63'b0, cnt_a}, 68'd0);
    repeat (3) step();
    @(negedge clk); check("mid_rel_ovalid", {66'b0, ov_a}, 68'd0);
    step();
    n = 0; cyc = 0;
    while ((n < 12 || cnt_b != 0) && cyc < 500) begin
      iv_b = (n < 12 && $urandom_range(3) != 0) ? 2'b11 : 2'b00;
      id_b = lanes(200 + n, 3 * n + 1);
      or_b = 2'($urandom_range(3));
      @(negedge clk);
      check("b_count_le_depth", {67'b0, cnt_b <= 3'd5}, 68'd1);
      if (ir_b) n++;
      step();
      cyc++;
    end
    iv_b = 0;
    check("b_timeout", {67'b0, cyc < 500}, 68'd1);
    check("b_pushed", 68'(n), 68'd12);
    for (int k = 0; k < 2; k++) begin
      check("a_drained", 68'(sb[0][k].size()), 68'd0);
      check("b_drained", 68'(sb[1][k].size()), 68'd0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_join_fork_buff.md
# stream_join_fork_buff

Parametrised elastic join/fork buffer for TyTra kernel tops: the next-generation replacement for the fixed-depth offset buffer plus hard-wired valid-AND/ready-AND glue used between a kernel's input streams and its functional units. It joins NIN input streams into one packed entry, holds up to DEPTH entries for latency balancing against deep parallel paths (e.g. mul→div chains), and forks each entry to NOUT consumers. Each consumer is tracked independently, so a stalled consumer never makes another consumer see a duplicate or lose data.

## Interface
- DATAW, 34, width of one stream lane (matches STREAMW)
- NIN, 2, number of joined input streams (≥1)
- NOUT, 2, number of forked consumers (≥1)
- DEPTH, 16, entry capacity (≥2, need not be a power of 2)
- AFULL_TH, 14, almost-full threshold (1..DEPTH)
- CNTW, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ivalid  in  NIN  per-input-stream valid
- in_data  in  NIN*DATAW  packed input lanes; lane i at [i*DATAW +: DATAW]
- iready  out  1  broadcast ready to all producers; high means the joined entry is accepted this cycle
- out_data  out  NIN*DATAW  head entry, shared by all consumers
- ovalid  out  NOUT  per-consumer valid
- oready  in  NOUT  per-consumer ready
- count  out  CNTW  current occupancy
- afull  out  1  count ≥ AFULL_TH

## Operation
- Storage: DEPTH×(NIN*DATAW) register array, plus wr_ptr, rd_ptr, count and done[NOUT]. The array is not reset.
- Join: iready = rst_deasserted & (count != DEPTH) & (&ivalid). Push happens when iready is high, writing in_data at wr_ptr. iready depends combinationally on ivalid. Producers must not make ivalid depend on iready.
- Fork:
  - ovalid[k] = (count != 0) & ~done[k].
  - Consumer k takes the head when ovalid[k] & oready[k]; done[k] is then set.
  - Pop when (count != 0) & &(done | oready).
  - On pop, all done bits clear and rd_ptr advances.
- out_data = mem[rd_ptr] when count != 0, else all-zero.
- Pointers wrap from DEPTH-1 to 0 (explicit compare, not modulo-2^n).
- count: +1 on push only, −1 on pop only, unchanged when both occur.
- Full: because iready uses the registered count, a pop in the same cycle does not free space for a push. With count == DEPTH, iready is 0 even while popping.
- Empty: a push into an empty buffer is not visible until the next cycle (no bypass).
- afull = (count ≥ AFULL_TH), derived from the registered count.

## Timing
- Reset (rst low, async): count=0, wr_ptr=rd_ptr=0, done=0. Outputs: iready=0, ovalid=0, out_data=0, count=0, afull=0.
- Release: iready may assert in the first cycle after rst rises, if all ivalid are high.
- Latency: push at edge N gives ovalid high after edge N (cycle N+1).
- Throughput: 1 entry/cycle when all oready are high and the buffer is neither full nor empty.
- Reset mid-operation: all contents discarded, done bits cleared, ovalid drops asynchronously.
- Consumers that have already taken the head see ovalid[k]=0 until the pop. There is no re-presentation of the same entry.

## Test plan
- Reset/idle: hold rst low with ivalid=2'b11 → iready=0, ovalid=0, count=0, out_data=0. Release → iready=1 on the next cycle.
- Partial join: ivalid=2'b01, lane0=34'h1 → iready=0, count stays 0. Set ivalid=2'b11, lane1=34'h2 → push, and one cycle later ovalid=2'b11, out_data={34'h2,34'h1}.
- Fill/full: oready=0, push 16 entries 0..15 → count=16, afull=1 from count=14, iready=0 at 16. Then oready=2'b11 with ivalid held → pops 0..15 in order. The 17th entry pushes only after count<16 is registered.
- Skewed fork: entry 34'hA5; oready=2'b01 for 3 cycles, then 2'b10 → ovalid=2'b10 after the first cycle. Pop happens on the cycle oready[1]=1, with count decrementing once and no duplicate on consumer 0.
- Wrap-around: DEPTH=5, stream 12 entries with random oready stalls → output sequence equals input sequence, and count never exceeds 5.
- Async reset mid-stream: assert rst with count=7 → ovalid=0 immediately. After release, count=0 and the old data is never presented.
